// File: rtl/cve2_rvfi_trace_buffer_if.sv
// Retirement-in / trace-out signal bundle for the RVFI trace buffer.
// The master side is the core plus the trace consumer; the slave side is the buffer.
interface cve2_rvfi_trace_buffer_if;
    // Retirement stream from the core's RVFI port
    logic        rvfi_valid;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_insn;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic        rvfi_trap;
    logic        rvfi_intr;

    // Drain stream towards debug/trace-port logic
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_insn;
    logic [4:0]  trace_rd_addr;
    logic [31:0] trace_rd_wdata;
    logic        trace_trap;
    logic        trace_intr;

    modport master (
        output rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
               rvfi_trap, rvfi_intr, trace_ready,
        input  trace_valid, trace_pc, trace_insn, trace_rd_addr, trace_rd_wdata,
               trace_trap, trace_intr
    );

    modport slave (
        input  rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
               rvfi_trap, rvfi_intr, trace_ready,
        output trace_valid, trace_pc, trace_insn, trace_rd_addr, trace_rd_wdata,
               trace_trap, trace_intr
    );
endinterface

// File: rtl/cve2_rvfi_trace_buffer.sv
// On-chip retirement trace buffer: captures RVFI records into a circular buffer,
// optionally after a PC trigger, in one-shot (freeze when full) or wrap (overwrite
// oldest) mode, and drains them head-first over a valid/ready stream.
module cve2_rvfi_trace_buffer #(
    parameter int unsigned Depth     = 16,
    parameter bit          CaptureRd = 1'b1,
    parameter int unsigned OvfWidth  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    wrap_mode_i,
    input  logic                    trig_en_i,
    input  logic [31:0]             trig_pc_i,
    input  logic                    clear_i,
    cve2_rvfi_trace_buffer_if.slave bus,
    output logic [$clog2(Depth):0]  level_o,
    output logic [OvfWidth-1:0]     ovf_cnt_o,
    output logic [1:0]              state_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StFrozen  = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        trap;
        logic        intr;
    } rec_t;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]     level_q, level_d;
    logic [OvfWidth-1:0] ovf_q, ovf_d;
    logic                wrap_q;
    rec_t                mem_q [Depth];
    rec_t                wr_rec;
    rec_t                head;

    logic full;
    logic retire;
    logic push;
    logic pop;
    logic overwrite;
    logic drop;
    logic wr_en;
    logic ovf_inc;

    // Decode this cycle's push/pop/overflow events and the next pointer/level/counter values
    always_comb begin
        full      = (level_q == LvlW'(Depth));
        retire    = bus.rvfi_valid & enable_i & ~clear_i;
        push      = retire & ((state_q == StCapture) ||
                              ((state_q == StArmed) && (bus.rvfi_pc_rdata == trig_pc_i)));
        pop       = bus.trace_valid & bus.trace_ready;
        overwrite = push & full & ~pop & wrap_q;
        drop      = push & full & ~pop & ~wrap_q;
        wr_en     = push & ~drop;
        ovf_inc   = overwrite | drop | (retire & (state_q == StFrozen));

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;

        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            // An overwrite evicts the oldest record, so the head moves just like a pop
            if (pop || overwrite) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (wr_en && !overwrite && !pop) begin
                level_d = level_q + LvlW'(1);
            end else if (!wr_en && pop) begin
                level_d = level_q - LvlW'(1);
            end
            if (ovf_inc && (ovf_q != '1)) begin
                ovf_d = ovf_q + OvfWidth'(1);
            end
        end
    end

    // Capture FSM next-state: clear restarts as if from IDLE, disabling always returns to IDLE
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            if (!enable_i) begin
                state_d = StIdle;
            end else if (trig_en_i) begin
                state_d = StArmed;
            end else begin
                state_d = StCapture;
            end
        end else if (!enable_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    state_d = trig_en_i ? StArmed : StCapture;
                StArmed,
                StCapture: begin
                    if (push && !wrap_q && (level_d == LvlW'(Depth))) begin
                        state_d = StFrozen;
                    end else if (push) begin
                        state_d = StCapture;
                    end
                end
                StFrozen:  state_d = StFrozen;
            endcase
        end
    end

    // Control state; wrap mode is only latched while capture is disabled
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            if (!enable_i) begin
                wrap_q <= wrap_mode_i;
            end
        end
    end

    // Record to store; rd fields are constant zero when not captured
    always_comb begin
        wr_rec.pc       = bus.rvfi_pc_rdata;
        wr_rec.insn     = bus.rvfi_insn;
        wr_rec.rd_addr  = CaptureRd ? bus.rvfi_rd_addr  : 5'd0;
        wr_rec.rd_wdata = CaptureRd ? bus.rvfi_rd_wdata : 32'd0;
        wr_rec.trap     = bus.rvfi_trap;
        wr_rec.intr     = bus.rvfi_intr;
    end

    // Record storage
    // NOTE: the storage array has no reset; entries are only observable once level_q covers them.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    // Head record read combinationally and forced to zero while the buffer is empty
    always_comb begin
        head               = mem_q[rd_ptr_q];
        bus.trace_valid    = (level_q != '0);
        bus.trace_pc       = bus.trace_valid ? head.pc : 32'd0;
        bus.trace_insn     = bus.trace_valid ? head.insn : 32'd0;
        bus.trace_rd_addr  = (bus.trace_valid && CaptureRd) ? head.rd_addr : 5'd0;
        bus.trace_rd_wdata = (bus.trace_valid && CaptureRd) ? head.rd_wdata : 32'd0;
        bus.trace_trap     = bus.trace_valid & head.trap;
        bus.trace_intr     = bus.trace_valid & head.intr;
    end

    assign level_o   = level_q;
    assign ovf_cnt_o = ovf_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// Directed bench for cve2_rvfi_trace_buffer (Depth=16): capture, trigger, one-shot,
// wrap, full push+pop, clear and asynchronous reset scenarios.
module tb_cve2_rvfi_trace_buffer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wrap_mode;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        clear;
    logic [4:0]  level;
    logic [15:0] ovf_cnt;
    logic [1:0]  state;

    int n_cmp;
    int n_err;

    cve2_rvfi_trace_buffer_if bus ();

    cve2_rvfi_trace_buffer #(
        .Depth    (16),
        .CaptureRd(1'b1),
        .OvfWidth (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .enable_i   (enable),
        .wrap_mode_i(wrap_mode),
        .trig_en_i  (trig_en),
        .trig_pc_i  (trig_pc),
        .clear_i    (clear),
        .bus        (bus),
        .level_o    (level),
        .ovf_cnt_o  (ovf_cnt),
        .state_o    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire_full(input logic [31:0] pc, input logic [31:0] insn,
                               input logic [4:0] rd, input logic [31:0] wd,
                               input logic trap, input logic intr);
        bus.rvfi_valid    = 1'b1;
        bus.rvfi_pc_rdata = pc;
        bus.rvfi_insn     = insn;
        bus.rvfi_rd_addr  = rd;
        bus.rvfi_rd_wdata = wd;
        bus.rvfi_trap     = trap;
        bus.rvfi_intr     = intr;
        tick();
        bus.rvfi_valid    = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc);
        retire_full(pc, ~pc, pc[6:2], pc + 32'd1, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        bus.trace_ready = 1'b1;
        tick();
        bus.trace_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (ovf_cnt !== 16'd0) begin n_err++; $display("FAIL reset_ovf: got %0d want 0", ovf_cnt); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (bus.trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.trace_valid); end
        n_cmp++; if ({bus.trace_pc, bus.trace_insn, bus.trace_rd_wdata} !== 96'd0) begin
            n_err++; $display("FAIL reset_data: got %h/%h/%h want zeros", bus.trace_pc, bus.trace_insn, bus.trace_rd_wdata);
        end
        n_cmp++; if ({bus.trace_rd_addr, bus.trace_trap, bus.trace_intr} !== 7'd0) begin
            n_err++; $display("FAIL reset_flags: got %h want 0", {bus.trace_rd_addr, bus.trace_trap, bus.trace_intr});
        end
    endtask

    task automatic test_basic_capture();
        logic [31:0] pc;
        enable = 1'b1;
        tick();
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL basic_state: got %0d want 2", state); end
        for (int i = 0; i < 5; i++) begin
            pc = 32'h80 + 32'(4 * i);
            retire_full(pc, 32'h13 + 32'(i), 5'(i + 1), 32'hA0 + 32'(i), (i == 2), (i == 3));
            if (i == 0) begin
                n_cmp++; if (bus.trace_valid !== 1'b1 || bus.trace_pc !== 32'h80) begin
                    n_err++; $display("FAIL basic_latency: valid %b pc %h want 1 00000080", bus.trace_valid, bus.trace_pc);
                end
            end
        end
        n_cmp++; if (level !== 5'd5) begin n_err++; $display("FAIL basic_level: got %0d want 5", level); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.trace_valid !== 1'b1 || bus.trace_pc !== 32'h80 + 32'(4 * i) ||
                bus.trace_insn !== 32'h13 + 32'(i) || bus.trace_rd_addr !== 5'(i + 1) ||
                bus.trace_rd_wdata !== 32'hA0 + 32'(i) || bus.trace_trap !== (i == 2) ||
                bus.trace_intr !== (i == 3)) begin
                n_err++;
                $display("FAIL basic_drain[%0d]: got v%b pc %h insn %h rd %0d wd %h t%b i%b want pc %h",
                         i, bus.trace_valid, bus.trace_pc, bus.trace_insn, bus.trace_rd_addr,
                         bus.trace_rd_wdata, bus.trace_trap, bus.trace_intr, 32'h80 + 32'(4 * i));
            end
            pop_one();
        end
        n_cmp++; if (bus.trace_valid !== 1'b0 || level !== 5'd0) begin
            n_err++; $display("FAIL basic_empty: valid %b level %0d want 0 0", bus.trace_valid, level);
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_trigger();
        trig_pc = 32'h1000;
        trig_en = 1'b1;
        enable  = 1'b1;
        tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL trig_armed: got %0d want 1", state); end
        retire(32'hFFC);
        n_cmp++; if (state !== 2'd1 || level !== 5'd0) begin
            n_err++; $display("FAIL trig_nomatch: state %0d level %0d want 1 0", state, level);
        end
        retire(32'h1000);
        n_cmp++; if (state !== 2'd2 || level !== 5'd1) begin
            n_err++; $display("FAIL trig_match: state %0d level %0d want 2 1", state, level);
        end
        retire(32'h1004);
        n_cmp++; if (level !== 5'd2 || bus.trace_pc !== 32'h1000) begin
            n_err++; $display("FAIL trig_head: level %0d pc %h want 2 00001000", level, bus.trace_pc);
        end
        pop_one();
        n_cmp++; if (bus.trace_pc !== 32'h1004) begin n_err++; $display("FAIL trig_second: got %h want 00001004", bus.trace_pc); end
        pop_one();
        enable  = 1'b0;
        trig_en = 1'b0;
        tick();
    endtask

    task automatic test_oneshot();
        wrap_mode = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            retire(32'h2000 + 32'(4 * i));
            if (i == 15) begin
                n_cmp++; if (state !== 2'd3 || level !== 5'd16) begin
                    n_err++; $display("FAIL oneshot_freeze: state %0d level %0d want 3 16", state, level);
                end
            end
        end
        n_cmp++; if (level !== 5'd16 || ovf_cnt !== 16'd4 || bus.trace_pc !== 32'h2000) begin
            n_err++; $display("FAIL oneshot_full: level %0d ovf %0d pc %h want 16 4 00002000", level, ovf_cnt, bus.trace_pc);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (bus.trace_pc !== 32'h2000 + 32'(4 * i)) begin
                n_err++; $display("FAIL oneshot_drain[%0d]: got %h want %h", i, bus.trace_pc, 32'h2000 + 32'(4 * i));
            end
            pop_one();
        end
        n_cmp++; if (state !== 2'd3 || level !== 5'd0 || bus.trace_valid !== 1'b0) begin
            n_err++; $display("FAIL oneshot_drained: state %0d level %0d valid %b want 3 0 0", state, level, bus.trace_valid);
        end
        enable = 1'b0;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
        n_cmp++; if (ovf_cnt !== 16'd0 || state !== 2'd0) begin
            n_err++; $display("FAIL oneshot_clear: ovf %0d state %0d want 0 0", ovf_cnt, state);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        wrap_mode = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            retire(32'h3000 + 32'(4 * i));
        end
        n_cmp++; if (level !== 5'd16 || ovf_cnt !== 16'd4 || state !== 2'd2) begin
            n_err++; $display("FAIL wrap_full: level %0d ovf %0d state %0d want 16 4 2", level, ovf_cnt, state);
        end
        n_cmp++; if (bus.trace_pc !== 32'h3010) begin n_err++; $display("FAIL wrap_head: got %h want 00003010", bus.trace_pc); end
        // Full push with pop: no overflow, oldest leaves normally
        bus.trace_ready = 1'b1;
        retire(32'h4000);
        bus.trace_ready = 1'b0;
        n_cmp++; if (level !== 5'd16 || ovf_cnt !== 16'd4 || bus.trace_pc !== 32'h3014) begin
            n_err++; $display("FAIL wrap_pushpop: level %0d ovf %0d pc %h want 16 4 00003014", level, ovf_cnt, bus.trace_pc);
        end
        for (int i = 0; i < 16; i++) begin
            exp_pc = (i < 15) ? 32'h3014 + 32'(4 * i) : 32'h4000;
            n_cmp++; if (bus.trace_pc !== exp_pc) begin
                n_err++; $display("FAIL wrap_drain[%0d]: got %h want %h", i, bus.trace_pc, exp_pc);
            end
            pop_one();
        end
        enable    = 1'b0;
        wrap_mode = 1'b0;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            retire(32'h5000 + 32'(4 * i));
        end
        enable = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd0 || level !== 5'd16) begin
            n_err++; $display("FAIL b2b_disable_keeps: state %0d level %0d want 0 16", state, level);
        end
        enable = 1'b1;
        tick();
        bus.trace_ready = 1'b1;
        retire(32'h6000);
        bus.trace_ready = 1'b0;
        n_cmp++; if (level !== 5'd16 || ovf_cnt !== 16'd0 || bus.trace_pc !== 32'h5004) begin
            n_err++; $display("FAIL b2b_oneshot_pushpop: level %0d ovf %0d pc %h want 16 0 00005004", level, ovf_cnt, bus.trace_pc);
        end
        for (int i = 0; i < 16; i++) begin
            exp_pc = (i < 15) ? 32'h5004 + 32'(4 * i) : 32'h6000;
            n_cmp++; if (bus.trace_pc !== exp_pc) begin
                n_err++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, bus.trace_pc, exp_pc);
            end
            pop_one();
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        bus.trace_ready = 1'b1;
        retire(32'h7000);
        bus.trace_ready = 1'b0;
        n_cmp++; if (level !== 5'd1 || bus.trace_pc !== 32'h7000) begin
            n_err++; $display("FAIL b2b_empty_pushpop: level %0d pc %h want 1 00007000", level, bus.trace_pc);
        end
        pop_one();
        enable = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            retire(32'h8000 + 32'(4 * i));
        end
        n_cmp++; if (ovf_cnt !== 16'd1 || state !== 2'd3) begin
            n_err++; $display("FAIL clear_setup: ovf %0d state %0d want 1 3", ovf_cnt, state);
        end
        clear = 1'b1;
        retire(32'h9000);
        clear = 1'b0;
        n_cmp++; if (level !== 5'd0 || ovf_cnt !== 16'd0 || bus.trace_valid !== 1'b0 || state !== 2'd2) begin
            n_err++; $display("FAIL clear_flush: level %0d ovf %0d valid %b state %0d want 0 0 0 2",
                              level, ovf_cnt, bus.trace_valid, state);
        end
        tick();
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL clear_discard: level %0d want 0", level); end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            retire(32'hA000 + 32'(4 * i));
        end
        pop_one();
        n_cmp++; if (level !== 5'd3 || bus.trace_pc !== 32'hA004) begin
            n_err++; $display("FAIL rst_setup: level %0d pc %h want 3 0000a004", level, bus.trace_pc);
        end
        bus.trace_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (level !== 5'd0 || state !== 2'd0 || bus.trace_valid !== 1'b0 || ovf_cnt !== 16'd0) begin
            n_err++; $display("FAIL rst_async: level %0d state %0d valid %b ovf %0d want 0 0 0 0",
                              level, state, bus.trace_valid, ovf_cnt);
        end
        bus.trace_ready = 1'b0;
        enable = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (state !== 2'd0 || level !== 5'd0) begin
            n_err++; $display("FAIL rst_after: state %0d level %0d want 0 0", state, level);
        end
    endtask

    initial begin
        n_cmp             = 0;
        n_err             = 0;
        rst_n             = 1'b0;
        enable            = 1'b0;
        wrap_mode         = 1'b0;
        trig_en           = 1'b0;
        trig_pc           = 32'd0;
        clear             = 1'b0;
        bus.rvfi_valid    = 1'b0;
        bus.rvfi_pc_rdata = 32'd0;
        bus.rvfi_insn     = 32'd0;
        bus.rvfi_rd_addr  = 5'd0;
        bus.rvfi_rd_wdata = 32'd0;
        bus.rvfi_trap     = 1'b0;
        bus.rvfi_intr     = 1'b0;
        bus.trace_ready   = 1'b0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic_capture();
        test_trigger();
        test_oneshot();
        test_wrap();
        test_back_to_back();
        test_clear();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
